systolic_feeder: RTL
====================

Name: systolic_feeder

Overview:
Upstream stage of the weight-stationary systolic array. It collects an NxN weight tile and pulses the array's load_weight once. It then accepts activation vectors and drives the array's left-edge a_in/valid inputs with the diagonal skew, delaying row i by i cycles. Finally it drains its skew pipeline and signals done.

Parameters:
N, 2, array dimension (rows = columns = N), N >= 2
DATA_W, 8, activation/weight element width, matches the PE datapath
CNT_W, 8, width of the vector count

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin a job; sampled only in IDLE
num_vectors  input  CNT_W  activation vectors in the job; latched on start
w_in  input  N*DATA_W  one weight row per beat; element c at [c*DATA_W +: DATA_W]
w_valid  input  1  w_in beat valid
w_ready  output  1  feeder accepts weight beat
act_in  input  N*DATA_W  one activation vector; element i is for array row i
act_valid  input  1  act_in valid
act_ready  output  1  feeder accepts activation vector
weight_out  output  N*N*DATA_W  weight for PE(r,c) at [(r*N+c)*DATA_W +: DATA_W]
load_weight  output  1  one-cycle strobe to all PEs
a_row_out  output  N*DATA_W  skewed activation to left-column PE of row i
valid_out  output  N  per-row valid to the left-column PEs
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at job end

Behaviour:
- Reset (async, any time, including mid-job): state=IDLE; all counters cleared; skew lines cleared. Outputs: weight_out=0, a_row_out=0, valid_out=0, load_weight=0, done=0, w_ready=0, act_ready=0. The partial job is discarded.
- States: IDLE, LOAD_W, COMMIT, STREAM, DRAIN.
- IDLE:
  - start && num_vectors!=0: latch num_vectors, row_cnt=0, go to LOAD_W.
  - start && num_vectors==0: pulse done next cycle, stay IDLE, weights untouched.
- LOAD_W: w_ready=1.
  - Each w_valid&&w_ready beat stores w_in into weight row row_cnt, then row_cnt++.
  - After the beat with row_cnt==N-1, go to COMMIT.
  - Weights go to a staging register; weight_out does not change during LOAD_W.
- COMMIT (exactly 1 cycle):
  - weight_out is registered from staging on entry, so it is stable in this cycle.
  - load_weight=1 for this cycle only; act_ready=0; next state STREAM with vec_cnt=0.
- STREAM: act_ready=1.
  - Every cycle, one slot enters the skew line: act_in if act_valid (vec_cnt++), otherwise a bubble (invalid, data 0). Bubbles keep the diagonal aligned.
  - When the accepting beat has vec_cnt==num_vectors-1, go to DRAIN.
- DRAIN: act_ready=0; bubbles enter for N-1 cycles (down-counter). After the last, go to IDLE and pulse done for 1 cycle in the first IDLE cycle.
- Skew timing:
  - Element i of a vector accepted at cycle t appears on a_row_out row i, with valid_out[i]=1, at cycle t+1+i.
  - Row 0 has 1 register stage; row i has 1+i stages.
- Invalid slots: when valid_out[i]=0, a_row_out row i = 0.
- Weight retention: weight_out holds its value after done until the next COMMIT or reset.
- Ignored inputs:
  - start while busy is ignored, and num_vectors is not re-latched.
  - w_valid outside LOAD_W and act_valid outside STREAM have no effect.
- Job latency: done comes N-1 cycles after the last vector leaves row 0 of the feeder's skew line (+1 to IDLE). The array's own propagation is the consumer's concern.

Decomposition:
- Shared package (tpu_pkg): state enum feeder_state_t {IDLE, LOAD_W, COMMIT, STREAM, DRAIN}; localparam DATA_W=8, shared with the PE.
- Sub-module skew_delay_line (params DEPTH, DATA_W): a DEPTH-stage shift register of {valid, data}, with async reset clearing all stages. One instance per row i with DEPTH=1+i, generated in a loop.

Test Plan:
- Weight load, N=2: start with num_vectors=1; beats w_in={2,1}, then {4,3}. Required: COMMIT cycle load_weight=1, and weight_out elements (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4; load_weight is 0 in every other cycle.
- Skew: 3 back-to-back vectors {row1,row0} = {0x11,0x10}, {0x21,0x20}, {0x31,0x30}, first accepted at t0.
  - Row 0 gives 0x10, 0x20, 0x30 at t0+1..t0+3.
  - Row 1 gives 0x11, 0x21, 0x31 at t0+2..t0+4.
  - valid_out matches exactly; done pulses at t0+5.
- Bubble: act_valid low for 1 cycle between vectors 1 and 2. Both rows show a single valid_out=0 gap with a_row_out=0, and diagonal alignment is preserved.
- Zero job: start with num_vectors=0 gives done=1 the next cycle; busy never rises; w_ready stays 0.
- Reset mid-STREAM: after 1 of 3 vectors, assert reset. Required immediately: valid_out=0, weight_out=0, busy=0. A new job afterwards completes normally.
- start during STREAM with a different num_vectors is ignored; the job finishes with the original count.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and constants for the systolic array datapath
package tpu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMMIT,
        STREAM,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - job, weight, activation and array-edge signals of the feeder
interface systolic_feeder_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic                     start;
    logic [CNT_W-1:0]         num_vectors;
    logic [N*DATA_W-1:0]      w_in;
    logic                     w_valid;
    logic                     w_ready;
    logic [N*DATA_W-1:0]      act_in;
    logic                     act_valid;
    logic                     act_ready;
    logic [N*N*DATA_W-1:0]    weight_out;
    logic                     load_weight;
    logic [N*DATA_W-1:0]      a_row_out;
    logic [N-1:0]             valid_out;
    logic                     busy;
    logic                     done;

    modport master (
        output start, num_vectors, w_in, w_valid, act_in, act_valid,
        input  w_ready, act_ready, weight_out, load_weight, a_row_out, valid_out, busy, done
    );

    modport slave (
        input  start, num_vectors, w_in, w_valid, act_in, act_valid,
        output w_ready, act_ready, weight_out, load_weight, a_row_out, valid_out, busy, done
    );

endinterface

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage {valid, data} shift register for one skewed array row
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - loads an NxN weight tile, then streams diagonally skewed activations
module systolic_feeder #(
    parameter int N      = 2,
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    systolic_feeder_if.slave   bus
);
    import tpu_pkg::*;

    localparam int ROW_W  = N * DATA_W;
    localparam int ROW_CW = $clog2(N);

    feeder_state_t           state_q, state_d;
    logic [ROW_CW-1:0]       row_cnt_q, row_cnt_d;
    logic [ROW_CW-1:0]       drain_q, drain_d;
    logic [CNT_W-1:0]        vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic [N*ROW_W-1:0]      stage_q, stage_d;
    logic [N*ROW_W-1:0]      weight_q, weight_d;
    logic                    done_q, done_d;
    logic                    accept;
    logic [N-1:0]            row_valid;
    logic [ROW_W-1:0]        row_data;

    assign accept = (state_q == STREAM) && bus.act_valid;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        drain_d   = drain_q;
        vec_cnt_d = vec_cnt_q;
        num_d     = num_q;
        stage_d   = stage_q;
        weight_d  = weight_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_vectors != '0) begin
                        num_d     = bus.num_vectors;
                        row_cnt_d = '0;
                        state_d   = LOAD_W;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (bus.w_valid) begin
                    stage_d[row_cnt_q*ROW_W +: ROW_W] = bus.w_in;
                    row_cnt_d = row_cnt_q + 1'b1;
                    // the final row is forwarded straight into weight_out so it is stable in COMMIT
                    if (row_cnt_q == ROW_CW'(N-1)) begin
                        weight_d = stage_d;
                        state_d  = COMMIT;
                    end
                end
            end
            COMMIT: begin
                vec_cnt_d = '0;
                state_d   = STREAM;
            end
            STREAM: begin
                if (bus.act_valid) begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                    if (vec_cnt_q == num_q - CNT_W'(1)) begin
                        drain_d = ROW_CW'(N-1);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            drain_q   <= '0;
            vec_cnt_q <= '0;
            num_q     <= '0;
            stage_q   <= '0;
            weight_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            drain_q   <= drain_d;
            vec_cnt_q <= vec_cnt_d;
            num_q     <= num_d;
            stage_q   <= stage_d;
            weight_q  <= weight_d;
            done_q    <= done_d;
        end
    end

    // row i gets 1+i stages; data is forced to zero on bubble slots
    for (genvar i = 0; i < N; i++) begin : g_row
        skew_delay_line #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_skew (
            .clk     (clk),
            .reset   (reset),
            .valid_i (accept),
            .data_i  (accept ? bus.act_in[i*DATA_W +: DATA_W] : {DATA_W{1'b0}}),
            .valid_o (row_valid[i]),
            .data_o  (row_data[i*DATA_W +: DATA_W])
        );
    end

    assign bus.w_ready     = (state_q == LOAD_W);
    assign bus.act_ready   = (state_q == STREAM);
    assign bus.load_weight = (state_q == COMMIT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.weight_out  = weight_q;
    assign bus.valid_out   = row_valid;
    assign bus.a_row_out   = row_data;

endmodule
